// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 max pooling using a half-width line buffer
//   clk, rst               clock, synchronous active-high reset
//   in_valid, data_in      raster-order input pixel stream
//   out_valid, data_out    one-cycle pulse per pooled pixel
//   frame_done             pulses with the last pooled pixel of a frame
//   POOL_SIGNED_EN         define for two's-complement compares (default unsigned)
module max_pool_2x2 #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int LN = IMG_WIDTH / 2;
   localparam int LW = LN > 1 ? $clog2(LN) : 1;
   function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef POOL_SIGNED_EN
      return $signed(a) > $signed(b) ? a : b;
`else
      return a > b ? a : b;
`endif
   endfunction
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic [DATA_WIDTH-1:0] lbuf_q [LN];
   logic [LW-1:0]         lb_idx;
   logic [DATA_WIDTH-1:0] m2;
   logic                  last_col, last_row, lb_we, emit;
   always_comb begin
      last_col     = col_q == CW'(IMG_WIDTH - 1);
      last_row     = row_q == RW'(IMG_HEIGHT - 1);
      lb_idx       = LW'(col_q >> 1);
      m2           = vmax(hold_q, data_in);
      lb_we        = in_valid && col_q[0] && !row_q[0];
      emit         = in_valid && col_q[0] && row_q[0];
      col_d        = in_valid ? (last_col ? '0 : col_q + CW'(1)) : col_q;
      row_d        = (in_valid && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
      hold_d       = (in_valid && !col_q[0]) ? data_in : hold_q;
      out_valid_d  = emit;
      data_out_d   = emit ? vmax(lbuf_q[lb_idx], m2) : data_out_q;
      frame_done_d = emit && last_col && last_row;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end
   // even-row pair maxima; always written before the odd row reads them
   always_ff @(posedge clk) begin
      if (lb_we) lbuf_q[lb_idx] <= m2;
   end
   assign out_valid  = out_valid_q;
   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed checks on a 4x4 instance plus a 28x28 golden-model frame
module tb_max_pool_2x2;
   logic       clk, rst;
   logic       iv4, ov4, fd4;
   logic [7:0] di4, do4;
   logic       iv28, ov28, fd28;
   logic [7:0] di28, do28;
   int         total, bad;
   logic [7:0] frm  [3][16];
   logic [7:0] exp4 [3][4];
   logic [15:0] vmask;
   logic [7:0] img  [784];
   logic [7:0] gold [196];
   logic [7:0] q28  [$];
   int         fd28_cnt;
   max_pool_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .data_in(di4),
      .out_valid(ov4), .data_out(do4), .frame_done(fd4)
   );
   max_pool_2x2 u28 (
      .clk(clk), .rst(rst), .in_valid(iv28), .data_in(di28),
      .out_valid(ov28), .data_out(do28), .frame_done(fd28)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(negedge clk) begin
      if (ov28) q28.push_back(do28);
      if (fd28) fd28_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask
   task automatic idle(input int n);
      iv4 = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_v", ov4, 0);
         chk("idle_fd", fd4, 0);
      end
   endtask
   task automatic push(input logic [7:0] px, input logic ev, input logic [7:0] ed, input logic ef, input string tag);
      iv4 = 1'b1;
      di4 = px;
      @(negedge clk);
      iv4 = 1'b0;
      chk({tag, "_v"}, ov4, ev);
      if (ev) chk({tag, "_d"}, do4, ed);
      chk({tag, "_fd"}, fd4, ef);
   endtask
   task automatic send_frame(input int sel, input int gap, input string tag);
      int k;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         push(frm[sel][i], vmask[i], exp4[sel][k > 3 ? 3 : k], i == 15, tag);
         if (vmask[i]) k++;
         if (gap > 0) idle(gap);
      end
   endtask
   initial begin
      total = 0; bad = 0; fd28_cnt = 0;
      rst = 1'b1; iv4 = 1'b0; di4 = '0; iv28 = 1'b0; di28 = '0;
      vmask = 16'hA0A0;
      for (int i = 0; i < 16; i++) begin
         frm[0][i] = 8'(i + 1);
         frm[1][i] = 8'hFF;
         frm[2][i] = 8'h00;
      end
      frm[2][0] = 8'hFD; frm[2][1] = 8'hF9; frm[2][2] = 8'h05; frm[2][3] = 8'hFE;
      frm[2][4] = 8'hFF; frm[2][5] = 8'h80;
      exp4[0] = '{8'd6, 8'd8, 8'd14, 8'd16};
      exp4[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef POOL_SIGNED_EN
      exp4[2] = '{8'hFF, 8'h05, 8'h00, 8'h00};
`else
      exp4[2] = '{8'hFF, 8'hFE, 8'h00, 8'h00};
`endif
      repeat (2) @(negedge clk);
      chk("rst_v", ov4, 0);
      chk("rst_d", do4, 0);
      chk("rst_fd", fd4, 0);
      rst = 1'b0;
      // 1: gap-free frame
      send_frame(0, 0, "t1");
      idle(2);
      // 2: three idle cycles between pixels
      send_frame(0, 3, "t2");
      idle(2);
      // 3: back-to-back frames, second saturated
      send_frame(0, 0, "t3a");
      send_frame(1, 0, "t3b");
      idle(2);
      // 4: reset after six pixels, then the frame again
      for (int i = 0; i < 6; i++) push(frm[0][i], vmask[i], 8'd6, 1'b0, "t4p");
      rst = 1'b1; iv4 = 1'b1; di4 = 8'd99;
      @(negedge clk);
      chk("t4_rst_v", ov4, 0);
      chk("t4_rst_d", do4, 0);
      chk("t4_rst_fd", fd4, 0);
      rst = 1'b0;
      idle(2);
      send_frame(0, 0, "t4");
      idle(2);
      // 5: negative values, signedness chosen at build time
      send_frame(2, 0, "t5");
      idle(2);
      // 6: default 28x28 against direct 2x2 max of the stored image
      for (int i = 0; i < 784; i++) img[i] = 8'($urandom_range(127, 0));
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < 14; c++) begin
            logic [7:0] m;
            m = img[(2*r)*28 + 2*c];
            if (img[(2*r)*28 + 2*c + 1] > m) m = img[(2*r)*28 + 2*c + 1];
            if (img[(2*r+1)*28 + 2*c] > m) m = img[(2*r+1)*28 + 2*c];
            if (img[(2*r+1)*28 + 2*c + 1] > m) m = img[(2*r+1)*28 + 2*c + 1];
            gold[r*14 + c] = m;
         end
      q28.delete();
      fd28_cnt = 0;
      for (int i = 0; i < 784; i++) begin
         iv28 = 1'b1;
         di28 = img[i];
         @(negedge clk);
      end
      iv28 = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_cnt", q28.size(), 196);
      chk("t6_fd", fd28_cnt, 1);
      for (int i = 0; i < 196; i++)
         if (i < q28.size()) chk($sformatf("t6_px%0d", i), q28[i], gold[i]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
